// File: rtl/ga_reg_ctrl.sv
// ga_reg_ctrl: gate-array register/config controller for the video colour path.
// Decodes CPU writes into pen select, ink palette, screen mode and ROM enables,
// and runs the 52-line raster interrupt counter with VSYNC resync and Z80 ack.
module ga_reg_ctrl #(
  parameter int INT_LINES = 52,
  parameter int VS_DELAY  = 2
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             cen_16,
  input  logic             CPU_WR,
  input  logic [7:0]       D,
  input  logic             HSYNC,
  input  logic             VSYNC,
  input  logic             INT_ACK,
  output logic [15:0][4:0] INKR,
  output logic [4:0]       BORDER,
  output logic [1:0]       MODE,
  output logic             LROMEN_N,
  output logic             HROMEN_N,
  output logic             INT_N
);

  localparam int VW = $clog2(VS_DELAY + 1);

  logic          r_hs_q;
  logic          r_vs_q;
  logic [3:0]    r_pen_sel;
  logic          r_pen_border;
  logic [1:0]    r_mode_pend;
  logic [5:0]    r_r52;
  logic [VW-1:0] r_vs_cnt;

  logic       w_wr;
  logic       w_hs_rise;
  logic       w_hs_fall;
  logic       w_vs_rise;
  logic       w_ack;
  logic       w_clr;
  logic       w_vs_hit;
  logic       w_raise;
  logic [5:0] w_r52_inc;
  logic [5:0] w_r52_nxt;
  logic       w_int_n_nxt;

  assign w_wr      = CPU_WR & cen_16;
  assign w_hs_rise = cen_16 &  HSYNC & ~r_hs_q;
  assign w_hs_fall = cen_16 & ~HSYNC &  r_hs_q;
  assign w_vs_rise = cen_16 &  VSYNC & ~r_vs_q;
  assign w_ack     = INT_ACK & cen_16;
  assign w_clr     = w_wr & (D[7:6] == 2'b10) & D[4];
  // A VSYNC re-rise in the same cycle restarts the delay instead of completing it
  assign w_vs_hit  = w_hs_fall & ~w_vs_rise & (r_vs_cnt == VW'(1));
  assign w_r52_inc = r_r52 + 6'd1;

  // Sample sync levels once per cen_16 tick for edge detection
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_hs_q <= 1'b0;
      r_vs_q <= 1'b0;
    end else if (cen_16) begin
      r_hs_q <= HSYNC;
      r_vs_q <= VSYNC;
    end
  end

  // CPU register writes; pending mode is promoted at HSYNC rise using the old value
  always_ff @(posedge clk) begin
    if (RESET) begin
      INKR         <= '0;
      BORDER       <= 5'd0;
      MODE         <= 2'd0;
      LROMEN_N     <= 1'b0;
      HROMEN_N     <= 1'b0;
      r_pen_sel    <= 4'd0;
      r_pen_border <= 1'b0;
      r_mode_pend  <= 2'd0;
    end else begin
      if (w_hs_rise) MODE <= r_mode_pend;
      if (w_wr) begin
        case (D[7:6])
          2'b00: begin
            if (D[4]) begin
              r_pen_border <= 1'b1;
            end else begin
              r_pen_border <= 1'b0;
              r_pen_sel    <= D[3:0];
            end
          end
          2'b01: begin
            if (r_pen_border) BORDER <= D[4:0];
            else              INKR[r_pen_sel] <= D[4:0];
          end
          2'b10: begin
            r_mode_pend <= D[1:0];
            LROMEN_N    <= D[2];
            HROMEN_N    <= D[3];
          end
          default: ;
        endcase
      end
    end
  end

  // VSYNC resync delay: armed on VSYNC rise, counts HSYNC falls down to idle (0)
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_vs_cnt <= '0;
    end else if (w_vs_rise) begin
      r_vs_cnt <= VW'(VS_DELAY);
    end else if (w_hs_fall && r_vs_cnt != '0) begin
      r_vs_cnt <= r_vs_cnt - VW'(1);
    end
  end

  // Next raster count and IRQ level: clear > resync > wrap raise > ack
  always_comb begin
    w_raise     = 1'b0;
    w_r52_nxt   = r_r52;
    w_int_n_nxt = INT_N;
    if (w_clr) begin
      w_r52_nxt   = 6'd0;
      w_int_n_nxt = 1'b1;
    end else begin
      if (w_vs_hit) begin
        w_r52_nxt = 6'd0;
        w_raise   = r_r52[5];
      end else if (w_hs_fall) begin
        if (w_r52_inc == 6'(INT_LINES)) begin
          w_r52_nxt = 6'd0;
          w_raise   = 1'b1;
        end else begin
          w_r52_nxt = w_r52_inc;
        end
      end
      if (w_ack) begin
        w_r52_nxt[5] = 1'b0;
        w_int_n_nxt  = 1'b1;
      end
      if (w_raise) w_int_n_nxt = 1'b0;
    end
  end

  // Raster counter and interrupt request registers
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_r52 <= 6'd0;
      INT_N <= 1'b1;
    end else if (cen_16) begin
      r_r52 <= w_r52_nxt;
      INT_N <= w_int_n_nxt;
    end
  end

endmodule
